menu_select_overlay: RTL and testbench

//  Parametrised menu screen generator for the VGA pipeline. Draws N_ITEMS stacked boxes plus a screen frame.

---
 rtl/menu_select_overlay.sv | 204 ++++++++++++++++++++
 tb/tb_menu_select_overlay.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_select_overlay.sv
// Menu screen overlay: draws a framed stack of N_ITEMS boxes, tracks a button-driven
// cursor, highlights the displayed selection (optionally blinking) and passes timing through 2 stages.
module menu_select_overlay #(
  parameter int          N_ITEMS      = 4,
  parameter int          H_ACTIVE     = 1024,
  parameter int          V_ACTIVE     = 768,
  parameter int          BOX_X0       = 362,
  parameter int          BOX_X1       = 674,
  parameter int          BOX_Y0       = 46,
  parameter int          BOX_H        = 100,
  parameter int          BOX_PITCH    = 192,
  parameter int          WRAP         = 1,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] HL_RGB       = 12'hff0,
  parameter logic [11:0] BOX_RGB      = 12'h333,
  parameter logic [11:0] EDGE_RGB     = 12'hfff,
  localparam int         IW           = $clog2(N_ITEMS)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [10:0]   hcount_in,
  input  logic [10:0]   vcount_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          hblnk_in,
  input  logic          vblnk_in,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_enter,
  output logic [10:0]   hcount_out,
  output logic [10:0]   vcount_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          hblnk_out,
  output logic          vblnk_out,
  output logic [11:0]   rgb_out,
  output logic [IW-1:0] cursor_idx,
  output logic [IW-1:0] sel_idx,
  output logic          sel_strobe
);

  localparam logic [IW-1:0] LAST_IDX   = IW'(N_ITEMS - 1);
  localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
  localparam logic [10:0]   X0         = 11'(BOX_X0);
  localparam logic [10:0]   X1         = 11'(BOX_X1);
  localparam logic [10:0]   H_LAST     = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   V_LAST     = 11'(V_ACTIVE - 1);

  logic [IW-1:0] r_cursor;
  logic [IW-1:0] r_disp_idx;
  logic [IW-1:0] r_sel_idx;
  logic          r_sel_strobe;
  logic          r_vsync_prev;
  logic          r_blink_off;
  logic [BW-1:0] r_blink_cnt;

  logic [IW-1:0] w_cursor_nxt;
  logic          w_frame_start;
  logic          w_phase_on;

  assign w_frame_start = vsync_in & ~r_vsync_prev;
  assign w_phase_on    = (BLINK_FRAMES == 0) || !r_blink_off;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_cursor_nxt = r_cursor;
    if (btn_up && !btn_down) begin
      if (r_cursor != '0)
        w_cursor_nxt = r_cursor - IW'(1);
      else if (WRAP != 0)
        w_cursor_nxt = LAST_IDX;
    end else if (btn_down && !btn_up) begin
      if (r_cursor != LAST_IDX)
        w_cursor_nxt = r_cursor + IW'(1);
      else if (WRAP != 0)
        w_cursor_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_cursor     <= '0;
      r_disp_idx   <= '0;
      r_sel_idx    <= '0;
      r_sel_strobe <= 1'b0;
      r_vsync_prev <= 1'b0;
      r_blink_off  <= 1'b0;
      r_blink_cnt  <= '0;
    end else begin
      r_cursor     <= w_cursor_nxt;
      r_sel_strobe <= btn_enter;
      if (btn_enter)
        r_sel_idx <= r_cursor;
      r_vsync_prev <= vsync_in;
      // The displayed selection only changes between frames to avoid tearing.
      if (w_frame_start) begin
        r_disp_idx <= r_cursor;
        if (BLINK_FRAMES == 0) begin
          r_blink_cnt <= '0;
          r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_off <= ~r_blink_off;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  logic [N_ITEMS-1:0] w_box_hit;
  logic               w_in_x;

  assign w_in_x = (hcount_in >= X0) && (hcount_in <= X1);

  for (genvar k = 0; k < N_ITEMS; k++) begin : g_box
    localparam logic [10:0] TOP = 11'(BOX_Y0 + k * BOX_PITCH);
    localparam logic [10:0] BOT = 11'(BOX_Y0 + k * BOX_PITCH + BOX_H);
    logic w_in_y;
    assign w_in_y       = (vcount_in >= TOP) && (vcount_in <= BOT);
    assign w_box_hit[k] = (((vcount_in == TOP) || (vcount_in == BOT)) && w_in_x) ||
                          (((hcount_in == X0) || (hcount_in == X1)) && w_in_y);
  end

  logic [10:0] r_s1_hcount, r_s1_vcount;
  logic        r_s1_hsync, r_s1_vsync, r_s1_hblnk, r_s1_vblnk;
  logic        r_s1_blank, r_s1_edge, r_s1_sel_outline, r_s1_any_outline;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_s1_hcount      <= '0;
      r_s1_vcount      <= '0;
      r_s1_hsync       <= 1'b0;
      r_s1_vsync       <= 1'b0;
      r_s1_hblnk       <= 1'b0;
      r_s1_vblnk       <= 1'b0;
      r_s1_blank       <= 1'b0;
      r_s1_edge        <= 1'b0;
      r_s1_sel_outline <= 1'b0;
      r_s1_any_outline <= 1'b0;
    end else begin
      r_s1_hcount      <= hcount_in;
      r_s1_vcount      <= vcount_in;
      r_s1_hsync       <= hsync_in;
      r_s1_vsync       <= vsync_in;
      r_s1_hblnk       <= hblnk_in;
      r_s1_vblnk       <= vblnk_in;
      r_s1_blank       <= hblnk_in | vblnk_in;
      r_s1_edge        <= (hcount_in == '0) || (hcount_in == H_LAST) ||
                          (vcount_in == '0) || (vcount_in == V_LAST);
      // Blink phase is folded in here so stage 2 is a pure priority mux.
      r_s1_sel_outline <= w_box_hit[r_disp_idx] & w_phase_on;
      r_s1_any_outline <= |w_box_hit;
    end
  end

  logic [11:0] w_rgb;

  always_comb begin
    w_rgb = 12'h000;
    if (r_s1_blank)            w_rgb = BOX_RGB;
    else if (r_s1_edge)        w_rgb = EDGE_RGB;
    else if (r_s1_sel_outline) w_rgb = HL_RGB;
    else if (r_s1_any_outline) w_rgb = BOX_RGB;
  end

  logic [10:0] r_hcount_out, r_vcount_out;
  logic        r_hsync_out, r_vsync_out, r_hblnk_out, r_vblnk_out;
  logic [11:0] r_rgb_out;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hcount_out <= '0;
      r_vcount_out <= '0;
      r_hsync_out  <= 1'b0;
      r_vsync_out  <= 1'b0;
      r_hblnk_out  <= 1'b0;
      r_vblnk_out  <= 1'b0;
      r_rgb_out    <= '0;
    end else begin
      r_hcount_out <= r_s1_hcount;
      r_vcount_out <= r_s1_vcount;
      r_hsync_out  <= r_s1_hsync;
      r_vsync_out  <= r_s1_vsync;
      r_hblnk_out  <= r_s1_hblnk;
      r_vblnk_out  <= r_s1_vblnk;
      r_rgb_out    <= w_rgb;
    end
  end

  assign hcount_out = r_hcount_out;
  assign vcount_out = r_vcount_out;
  assign hsync_out  = r_hsync_out;
  assign vsync_out  = r_vsync_out;
  assign hblnk_out  = r_hblnk_out;
  assign vblnk_out  = r_vblnk_out;
  assign rgb_out    = r_rgb_out;
  assign cursor_idx = r_cursor;
  assign sel_idx    = r_sel_idx;
  assign sel_strobe = r_sel_strobe;

endmodule

// File: tb/tb_menu_select_overlay.sv
// Bench for menu_select_overlay: three parameterisations driven in parallel and
// compared against a frame/cursor/pixel reference model built from the menu rules.
`timescale 1ns/1ps
module tb_menu_select_overlay;
  localparam int          N     = 4;
  localparam int          IW    = 2;
  localparam logic [11:0] HL    = 12'hff0;
  localparam logic [11:0] BOXC  = 12'h333;
  localparam logic [11:0] EDGEC = 12'hfff;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;

  logic [10:0]   o_hc[3], o_vc[3];
  logic          o_hs[3], o_vs[3], o_hb[3], o_vb[3], o_strobe[3];
  logic [11:0]   o_rgb[3];
  logic [IW-1:0] o_cur[3], o_sel[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  // Instance 0: defaults. Instance 1: saturating cursor, 2-frame blink. Instance 2: no blink.
  menu_select_overlay u_a (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .hcount_out(o_hc[0]), .vcount_out(o_vc[0]), .hsync_out(o_hs[0]), .vsync_out(o_vs[0]),
    .hblnk_out(o_hb[0]), .vblnk_out(o_vb[0]), .rgb_out(o_rgb[0]),
    .cursor_idx(o_cur[0]), .sel_idx(o_sel[0]), .sel_strobe(o_strobe[0]));

  menu_select_overlay #(.WRAP(0), .BLINK_FRAMES(2)) u_b (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .hcount_out(o_hc[1]), .vcount_out(o_vc[1]), .hsync_out(o_hs[1]), .vsync_out(o_vs[1]),
    .hblnk_out(o_hb[1]), .vblnk_out(o_vb[1]), .rgb_out(o_rgb[1]),
    .cursor_idx(o_cur[1]), .sel_idx(o_sel[1]), .sel_strobe(o_strobe[1]));

  menu_select_overlay #(.BLINK_FRAMES(0)) u_c (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .hcount_out(o_hc[2]), .vcount_out(o_vc[2]), .hsync_out(o_hs[2]), .vsync_out(o_vs[2]),
    .hblnk_out(o_hb[2]), .vblnk_out(o_vb[2]), .rgb_out(o_rgb[2]),
    .cursor_idx(o_cur[2]), .sel_idx(o_sel[2]), .sel_strobe(o_strobe[2]));

  // Reference model state
  int          m_cur[3], m_disp[3], m_sel[3];
  bit          m_strobe[3];
  int          m_frames;
  bit          m_vs_prev;
  logic [11:0] m_rgb1[3], m_rgb2[3];
  logic [25:0] m_tim1, m_tim2;

  function automatic int bf_of(int i);
    if (i == 0) return 30;
    if (i == 1) return 2;
    return 0;
  endfunction

  function automatic bit wraps(int i);
    return (i != 1);
  endfunction

  function automatic bit phase_on(int i);
    if (bf_of(i) == 0) return 1'b1;
    return ((m_frames / bf_of(i)) % 2) == 0;
  endfunction

  function automatic logic [11:0] ref_rgb(int h, int v, bit hb, bit vb, int disp, bit on);
    bit any_hit = 1'b0;
    bit mine    = 1'b0;
    if (hb || vb) return BOXC;
    if (h == 0 || h == 1023 || v == 0 || v == 767) return EDGEC;
    for (int k = 0; k < N; k++) begin
      int t;
      int b;
      t = 46 + k * 192;
      b = t + 100;
      if (((v == t || v == b) && h >= 362 && h <= 674) ||
          ((h == 362 || h == 674) && v >= t && v <= b)) begin
        any_hit = 1'b1;
        if (k == disp) mine = 1'b1;
      end
    end
    if (mine && on) return HL;
    if (any_hit) return BOXC;
    return 12'h000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = 0; m_disp[i] = 0; m_sel[i] = 0; m_strobe[i] = 1'b0;
      m_rgb1[i] = '0; m_rgb2[i] = '0;
    end
    m_frames = 0; m_vs_prev = 1'b0; m_tim1 = '0; m_tim2 = '0;
  endtask

  // Advance the model by one clock edge from the currently driven inputs, then step the clock.
  task automatic tick();
    int old_cur[3];
    bit rise;
    rise = vsync_in && !m_vs_prev;
    m_tim2 = m_tim1;
    m_tim1 = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    for (int i = 0; i < 3; i++) begin
      old_cur[i] = m_cur[i];
      m_rgb2[i]  = m_rgb1[i];
      m_rgb1[i]  = ref_rgb(int'(hcount_in), int'(vcount_in), hblnk_in, vblnk_in, m_disp[i], phase_on(i));
      m_strobe[i] = btn_enter;
      if (btn_enter) m_sel[i] = old_cur[i];
      if (btn_up && !btn_down)
        m_cur[i] = (old_cur[i] == 0) ? (wraps(i) ? N - 1 : 0) : old_cur[i] - 1;
      else if (btn_down && !btn_up)
        m_cur[i] = (old_cur[i] == N - 1) ? (wraps(i) ? 0 : N - 1) : old_cur[i] + 1;
      if (rise) m_disp[i] = old_cur[i];
    end
    if (rise) m_frames++;
    m_vs_prev = vsync_in;
    @(posedge pclk);
    #1;
  endtask

  task automatic press(bit up, bit down, bit enter);
    btn_up = up; btn_down = down; btn_enter = enter;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0;
  endtask

  task automatic frame_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic set_pixel(int h, int v, bit hb);
    hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = hb; vblnk_in = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 12; c++) begin
      hcount_in = 11'(100 + c); vcount_in = 11'(40 + c); hsync_in = c[0];
      btn_down = (c == 3); btn_enter = (c == 6);
      tick();
      n_checks++;
      if ({o_hc[0], o_vc[0], o_hs[0], o_vs[0], o_hb[0], o_vb[0]} !== m_tim2) begin
        n_fail++;
        $display("FAIL prereset_timing: got %h expected %h",
                 {o_hc[0], o_vc[0], o_hs[0], o_vs[0], o_hb[0], o_vb[0]}, m_tim2);
      end
    end
    btn_down = 1'b0; btn_enter = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({o_hc[i], o_vc[i], o_hs[i], o_vs[i], o_hb[i], o_vb[i], o_rgb[i], o_cur[i], o_sel[i], o_strobe[i]} !== '0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: outputs %h expected all zero", i,
                 {o_hc[i], o_vc[i], o_hs[i], o_vs[i], o_hb[i], o_vb[i], o_rgb[i], o_cur[i], o_sel[i], o_strobe[i]});
      end
    end
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    hcount_in = 11'd5; vcount_in = 11'd5; hsync_in = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (o_hc[0] !== 11'd0) begin
      n_fail++; $display("FAIL reset_latency1: hcount_out=%0d expected 0", o_hc[0]);
    end
    tick();
    n_checks++;
    if (o_hc[0] !== 11'd5) begin
      n_fail++; $display("FAIL reset_latency2: hcount_out=%0d expected 5", o_hc[0]);
    end
    n_checks++;
    if (o_rgb[0] !== m_rgb2[0]) begin
      n_fail++; $display("FAIL reset_rgb: rgb_out=%h expected %h", o_rgb[0], m_rgb2[0]);
    end
  endtask

  task automatic test_navigation();
    int seq[4] = '{0, 1, 2, 3};
    press(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_cur[0] !== 2'd3) begin
      n_fail++; $display("FAIL nav_wrap_up: cursor_idx=%0d expected 3", o_cur[0]);
    end
    n_checks++;
    if (o_cur[1] !== 2'd0) begin
      n_fail++; $display("FAIL nav_sat_up: cursor_idx=%0d expected 0", o_cur[1]);
    end
    for (int s = 0; s < 4; s++) begin
      press(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (o_cur[0] !== 2'(seq[s])) begin
        n_fail++; $display("FAIL nav_wrap_down%0d: cursor_idx=%0d expected %0d", s, o_cur[0], seq[s]);
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (o_cur[i] !== 2'(m_cur[i])) begin
          n_fail++; $display("FAIL nav_down%0d[%0d]: cursor_idx=%0d expected %0d", s, i, o_cur[i], m_cur[i]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_cur[i] !== 2'd2 || m_cur[i] != 2) begin
        n_fail++; $display("FAIL both_buttons[%0d]: cursor_idx=%0d expected 2", i, o_cur[i]);
      end
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({o_strobe[i], o_sel[i], o_cur[i]} !== {1'b1, 2'd1, 2'd2}) begin
        n_fail++; $display("FAIL enter_down[%0d]: strobe/sel/cursor=%b/%0d/%0d expected 1/1/2",
                           i, o_strobe[i], o_sel[i], o_cur[i]);
      end
    end
    tick();
    n_checks++;
    if ({o_strobe[0], o_sel[0]} !== {1'b0, 2'(m_sel[0])}) begin
      n_fail++; $display("FAIL enter_hold: strobe/sel=%b/%0d expected 0/%0d", o_strobe[0], o_sel[0], m_sel[0]);
    end
  endtask

  task automatic test_tearing();
    press(1'b1, 1'b0, 1'b0);
    set_pixel(400, 238, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (o_rgb[0] !== BOXC) begin
      n_fail++; $display("FAIL no_tearing: rgb_out=%h expected %h", o_rgb[0], BOXC);
    end
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (o_rgb[i] !== m_rgb2[i]) begin
          n_fail++; $display("FAIL frame_switch%0d[%0d]: rgb_out=%h expected %h", c, i, o_rgb[i], m_rgb2[i]);
        end
      end
    end
    n_checks++;
    if (o_rgb[0] !== HL) begin
      n_fail++; $display("FAIL frame_switch_hl: rgb_out=%h expected %h", o_rgb[0], HL);
    end
  endtask

  task automatic test_pixels();
    int          px[6]  = '{400, 362, 674, 500, 0, 400};
    int          py[6]  = '{46, 100, 300, 500, 300, 46};
    bit          phb[6] = '{0, 0, 0, 0, 0, 1};
    logic [11:0] want[6];
    want = '{HL, HL, BOXC, 12'h000, EDGEC, BOXC};
    press(1'b1, 1'b0, 1'b0);
    frame_pulse();
    for (int p = 0; p < 6; p++) begin
      set_pixel(px[p], py[p], phb[p]);
      tick();
      tick();
      n_checks++;
      if (o_rgb[0] !== want[p]) begin
        n_fail++; $display("FAIL pixel(%0d,%0d): rgb_out=%h expected %h", px[p], py[p], o_rgb[0], want[p]);
      end
      n_checks++;
      if (o_rgb[2] !== want[p]) begin
        n_fail++; $display("FAIL pixel_noblink(%0d,%0d): rgb_out=%h expected %h", px[p], py[p], o_rgb[2], want[p]);
      end
      n_checks++;
      if (o_rgb[1] !== m_rgb2[1]) begin
        n_fail++; $display("FAIL pixel_blink(%0d,%0d): rgb_out=%h expected %h", px[p], py[p], o_rgb[1], m_rgb2[1]);
      end
    end
    hblnk_in = 1'b0;
  endtask

  task automatic test_blink();
    logic [11:0] want;
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    model_reset();
    set_pixel(400, 46, 1'b0);
    for (int f = 0; f < 8; f++) begin
      tick();
      tick();
      want = ((f % 4) < 2) ? HL : BOXC;
      n_checks++;
      if (o_rgb[1] !== want || m_rgb2[1] !== want) begin
        n_fail++; $display("FAIL blink_frame%0d: rgb_out=%h expected %h", f, o_rgb[1], want);
      end
      n_checks++;
      if (o_rgb[2] !== HL) begin
        n_fail++; $display("FAIL blink_off_frame%0d: rgb_out=%h expected %h", f, o_rgb[2], HL);
      end
      frame_pulse();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        hcount_in = 11'($urandom_range(0, 1100));
        vcount_in = 11'($urandom_range(0, 800));
      end else begin
        int t;
        t = 46 + $urandom_range(0, N - 1) * 192;
        case ($urandom_range(0, 3))
          0:       hcount_in = 11'd362;
          1:       hcount_in = 11'd674;
          2:       hcount_in = 11'($urandom_range(355, 680));
          default: hcount_in = ($urandom_range(0, 1) == 1) ? 11'd0 : 11'd1023;
        endcase
        case ($urandom_range(0, 3))
          0:       vcount_in = 11'(t);
          1:       vcount_in = 11'(t + 100);
          2:       vcount_in = 11'(t + $urandom_range(0, 100));
          default: vcount_in = 11'($urandom_range(t - 3, t + 103));
        endcase
      end
      hblnk_in  = ($urandom_range(0, 15) == 0);
      vblnk_in  = ($urandom_range(0, 15) == 0);
      hsync_in  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) vsync_in = ~vsync_in;
      btn_up    = ($urandom_range(0, 7) == 0);
      btn_down  = ($urandom_range(0, 7) == 0);
      btn_enter = ($urandom_range(0, 9) == 0);
      tick();
      n_checks++;
      if ({o_hc[0], o_vc[0], o_hs[0], o_vs[0], o_hb[0], o_vb[0]} !== m_tim2) begin
        n_fail++;
        $display("FAIL rand%0d_timing: got %h expected %h", c,
                 {o_hc[0], o_vc[0], o_hs[0], o_vs[0], o_hb[0], o_vb[0]}, m_tim2);
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (o_rgb[i] !== m_rgb2[i]) begin
          n_fail++; $display("FAIL rand%0d_rgb[%0d]: got %h expected %h", c, i, o_rgb[i], m_rgb2[i]);
        end
        n_checks++;
        if ({o_cur[i], o_sel[i], o_strobe[i]} !== {2'(m_cur[i]), 2'(m_sel[i]), m_strobe[i]}) begin
          n_fail++; $display("FAIL rand%0d_ctrl[%0d]: cur/sel/strobe=%0d/%0d/%b expected %0d/%0d/%b",
                             c, i, o_cur[i], o_sel[i], o_strobe[i], m_cur[i], m_sel[i], m_strobe[i]);
        end
      end
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    rst = 1'b0;
    test_reset();
    test_navigation();
    test_simultaneous();
    test_tearing();
    test_pixels();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
